// File: rtl/sc_alien_scan_sequencer.sv
// Sweeps the alien index counter once per frame, hit-checking live
// aliens over a req/ack handshake and totalling the acked ones.
module sc_alien_scan_sequencer #(
  parameter int DATAWIDTH_BUS  = 5,
  parameter int ALIVECOUNT_BUS = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      SC_COUNTER_CLOCK_50,
  input  logic                      SC_COUNTER_RESET_InLow,
  input  logic                      SC_SCAN_start_InLow,
  input  logic [DATAWIDTH_BUS-1:0]  SC_SCAN_index_InBus,
  input  logic                      SC_SCAN_eoc_InLow,
  input  logic                      SC_SCAN_alive_In,
  input  logic                      SC_SCAN_ack_In,
  output logic                      SC_SCAN_count_OutLow,
  output logic                      SC_SCAN_req_Out,
  output logic                      SC_SCAN_busy_Out,
  output logic                      SC_SCAN_done_OutLow,
  output logic [ALIVECOUNT_BUS-1:0] SC_SCAN_alivecount_OutBus,
  output logic                      SC_SCAN_timeout_Out,
  output logic                      SC_SCAN_syncerr_Out
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_ACK,
    STEP,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic                      last_q, last_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      req_q, req_d;
  logic                      busy_q, busy_d;
  logic                      done_n_q, done_n_d;
  logic [ALIVECOUNT_BUS-1:0] alivecount_q, alivecount_d;
  logic                      timeout_q, timeout_d;
  logic                      syncerr_q, syncerr_d;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    timer_d      = timer_q;
    req_d        = req_q;
    busy_d       = busy_q;
    done_n_d     = done_n_q;
    alivecount_d = alivecount_q;
    timeout_d    = timeout_q;
    syncerr_d    = syncerr_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!SC_SCAN_start_InLow) begin
          state_d      = CHECK;
          busy_d       = 1'b1;
          alivecount_d = '0;
          timeout_d    = 1'b0;
          syncerr_d    = (SC_SCAN_index_InBus != '0);
        end
      end
      CHECK: begin
        last_d = ~SC_SCAN_eoc_InLow;
        if (SC_SCAN_alive_In) begin
          req_d   = 1'b1;
          timer_d = '0;
          state_d = WAIT_ACK;
        end else begin
          state_d = STEP;
        end
      end
      WAIT_ACK: begin
        // ack takes priority over an expiring timer
        if (SC_SCAN_ack_In) begin
          req_d   = 1'b0;
          state_d = STEP;
          if (alivecount_q != '1)
            alivecount_d = alivecount_q + 1'b1;
        end else if (timer_q == TLAST) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = STEP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STEP: begin
        if (last_q) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_n_d = 1'b0;
        end else begin
          state_d = CHECK;
        end
      end
      DONE: begin
        done_n_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SC_COUNTER_CLOCK_50 or
              negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      state_q      <= IDLE;
      last_q       <= 1'b0;
      timer_q      <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_n_q     <= 1'b1;
      alivecount_q <= '0;
      timeout_q    <= 1'b0;
      syncerr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      timer_q      <= timer_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      done_n_q     <= done_n_d;
      alivecount_q <= alivecount_d;
      timeout_q    <= timeout_d;
      syncerr_q    <= syncerr_d;
    end
  end

  // decoded from state so the counter steps at the edge closing STEP
  assign SC_SCAN_count_OutLow      = (state_q != STEP);
  assign SC_SCAN_req_Out           = req_q;
  assign SC_SCAN_busy_Out          = busy_q;
  assign SC_SCAN_done_OutLow       = done_n_q;
  assign SC_SCAN_alivecount_OutBus = alivecount_q;
  assign SC_SCAN_timeout_Out       = timeout_q;
  assign SC_SCAN_syncerr_Out       = syncerr_q;

endmodule
